// File: rtl/act_pkg.sv
// Shared definitions for the ACT-S2 arbiter: FSM states and select-field bit offsets.
package act_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  // Bit positions of {A1,B1,A0,B0} inside each requester's 4-bit select field
  localparam int unsigned SEL_A1 = 3;
  localparam int unsigned SEL_B1 = 2;
  localparam int unsigned SEL_A0 = 1;
  localparam int unsigned SEL_B0 = 0;

endpackage

// File: rtl/act_s2_arbiter_if.sv
// Requester-side bundle of the ACT-S2 arbiter: packed per-requester operands in, grant/result out.
interface act_s2_arbiter_if #(
  parameter int bits = 8,
  parameter int N    = 4
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]      req;
  logic [N*bits-1:0] d00_bus;
  logic [N*bits-1:0] d01_bus;
  logic [N*bits-1:0] d10_bus;
  logic [N*bits-1:0] d11_bus;
  logic [4*N-1:0]    sel_bus;
  logic [N-1:0]      grant;
  logic              busy;
  logic              done;
  logic [IDW-1:0]    done_id;
  logic [bits-1:0]   result;

  modport slave (
    input  req, d00_bus, d01_bus, d10_bus, d11_bus, sel_bus,
    output grant, busy, done, done_id, result
  );

  modport master (
    output req, d00_bus, d01_bus, d10_bus, d11_bus, sel_bus,
    input  grant, busy, done, done_id, result
  );

endinterface

// File: rtl/act_s2_cell_sync.sv
// Registered ACT-S2 cell: 4:1 mux with S1 = A1|B1, S0 = A0&B0, synchronous reset and load enable.
module act_s2_cell_sync #(
  parameter int bits = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic [bits-1:0] d00,
  input  logic [bits-1:0] d01,
  input  logic [bits-1:0] d10,
  input  logic [bits-1:0] d11,
  input  logic            a1,
  input  logic            b1,
  input  logic            a0,
  input  logic            b0,
  output logic [bits-1:0] q
);

  logic            s1;
  logic            s0;
  logic [bits-1:0] mux;

  always_comb begin
    s1  = a1 | b1;
    s0  = a0 & b0;
    mux = d00;
    case ({s1, s0})
      2'b00:   mux = d00;
      2'b01:   mux = d01;
      2'b10:   mux = d10;
      default: mux = d11;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= mux;
    end
  end

endmodule

// File: rtl/act_s2_arbiter.sv
// Round-robin arbiter sharing one registered ACT-S2 cell among N requesters (IDLE -> ISSUE -> CAPTURE).
module act_s2_arbiter
  import act_pkg::*;
#(
  parameter int bits = 8,
  parameter int N    = 4
) (
  input  logic            clock,
  input  logic            reset,
  act_s2_arbiter_if.slave bus
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  state_t          state;
  state_t          state_nx;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  win_id;
  logic [IDW-1:0]  pick;
  logic [IDW-1:0]  done_id_q;
  logic [bits-1:0] op_d00;
  logic [bits-1:0] op_d01;
  logic [bits-1:0] op_d10;
  logic [bits-1:0] op_d11;
  logic [3:0]      op_sel;
  logic            accept;
  logic [bits-1:0] cell_q;

  // First set request bit at or above p, wrapping N-1 -> 0
  function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] r, input logic [IDW-1:0] p);
    logic [IDW-1:0] w;
    logic [IDW-1:0] sidx;
    logic           found;
    int unsigned    idx;
    w     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx  = (int'(p) + i) % N;
      sidx = IDW'(idx);
      if (!found && r[sidx]) begin
        w     = sidx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  always_comb begin
    pick   = rr_pick(bus.req, rr_ptr);
    accept = (state == ST_IDLE) && (|bus.req);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (|bus.req) state_nx = ST_ISSUE;
      ST_ISSUE:   state_nx = ST_CAPTURE;
      ST_CAPTURE: state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr    <= '0;
      win_id    <= '0;
      done_id_q <= '0;
      op_d00    <= '0;
      op_d01    <= '0;
      op_d10    <= '0;
      op_d11    <= '0;
      op_sel    <= '0;
    end else begin
      if (accept) begin
        win_id <= pick;
        op_d00 <= bus.d00_bus[pick*bits +: bits];
        op_d01 <= bus.d01_bus[pick*bits +: bits];
        op_d10 <= bus.d10_bus[pick*bits +: bits];
        op_d11 <= bus.d11_bus[pick*bits +: bits];
        op_sel <= bus.sel_bus[pick*4 +: 4];
      end
      // done_id is loaded alongside the cell register so both hold until the next capture
      if (state == ST_ISSUE) begin
        done_id_q <= win_id;
      end
      if (state == ST_CAPTURE) begin
        rr_ptr <= (win_id == IDW'(N - 1)) ? '0 : win_id + 1'b1;
      end
    end
  end

  act_s2_cell_sync #(
    .bits(bits)
  ) u_cell (
    .clock (clock),
    .reset (reset),
    .load  (state == ST_ISSUE),
    .d00   (op_d00),
    .d01   (op_d01),
    .d10   (op_d10),
    .d11   (op_d11),
    .a1    (op_sel[SEL_A1]),
    .b1    (op_sel[SEL_B1]),
    .a0    (op_sel[SEL_A0]),
    .b0    (op_sel[SEL_B0]),
    .q     (cell_q)
  );

  always_comb begin
    bus.grant = '0;
    if (state == ST_ISSUE) begin
      bus.grant[win_id] = 1'b1;
    end
    bus.busy    = (state != ST_IDLE);
    bus.done    = (state == ST_CAPTURE);
    bus.done_id = done_id_q;
    bus.result  = cell_q;
  end

endmodule

// File: tb/tb_act_s2_arbiter.sv
// Bench for act_s2_arbiter: vector table, directed multi-cycle sequences, random run against a transaction model.
module tb_act_s2_arbiter;

  localparam int BITS = 8;
  localparam int NR   = 4;

  logic clock = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  act_s2_arbiter_if #(.bits(BITS), .N(NR)) bus ();

  act_s2_arbiter #(.bits(BITS), .N(NR)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  logic [7:0] ops [NR][4];
  logic [3:0] sels [NR];

  typedef struct {
    logic [3:0] req;
    logic [3:0] sel;
    logic [7:0] d00;
    logic [7:0] d01;
    logic [7:0] d10;
    logic [7:0] d11;
    logic [7:0] exp_result;
    logic [1:0] exp_id;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic apply;
    for (int i = 0; i < NR; i++) begin
      bus.d00_bus[i*BITS +: BITS] = ops[i][0];
      bus.d01_bus[i*BITS +: BITS] = ops[i][1];
      bus.d10_bus[i*BITS +: BITS] = ops[i][2];
      bus.d11_bus[i*BITS +: BITS] = ops[i][3];
      bus.sel_bus[i*4 +: 4]       = sels[i];
    end
  endtask

  task automatic scramble;
    for (int i = 0; i < NR; i++) begin
      for (int j = 0; j < 4; j++) ops[i][j] = 8'($urandom);
      sels[i] = 4'($urandom);
    end
  endtask

  function automatic int oh2i(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return -1;
  endfunction

  function automatic logic [15:0] outs;
    return {bus.grant, bus.busy, bus.done, bus.done_id, bus.result};
  endfunction

  task automatic serve(input logic [3:0] mask, output int w);
    int n;
    w = -1;
    n = 0;
    bus.req = mask;
    do begin
      tick;
      n++;
    end while (bus.grant == '0 && n < 10);
    if (bus.grant == '0) begin
      chk("serve_timeout", 32'd0, 32'd1);
      bus.req = '0;
      return;
    end
    w = oh2i(bus.grant);
    bus.req = '0;
    tick;
    chk("serve_done", {bus.done, bus.done_id}, {1'b1, 2'(w)});
    tick;
  endtask

  // Random-phase reference model: transactions scheduled on an edge timeline
  int         m_free, m_acc, m_rr, m_w;
  logic [7:0] m_res, m_last_res;
  logic [1:0] m_last_id;
  logic [15:0] e_out;

  task automatic model_edge(input int t);
    logic [3:0] eg;
    logic       eb, ed;
    if (reset) begin
      m_free = t + 1; m_acc = -10; m_rr = 0;
      m_last_res = '0; m_last_id = '0;
      e_out = '0;
      return;
    end
    if (t >= m_free && bus.req != 0) begin
      int w;
      int s;
      w = -1;
      for (int k = 0; k < NR; k++) begin
        int idx;
        idx = (m_rr + k) % NR;
        if (w < 0 && bus.req[idx]) w = idx;
      end
      s = 2 * int'(sels[w][3] | sels[w][2]) + int'(sels[w][1] & sels[w][0]);
      m_res = ops[w][s];
      m_w = w; m_acc = t; m_free = t + 3; m_rr = (w + 1) % NR;
    end
    eg = '0; eb = 1'b0; ed = 1'b0;
    if (m_acc == t) begin
      eg = 4'(1 << m_w); eb = 1'b1;
    end else if (m_acc == t - 1) begin
      eb = 1'b1; ed = 1'b1;
      m_last_res = m_res; m_last_id = 2'(m_w);
    end
    e_out = {eg, eb, ed, m_last_id, m_last_res};
  endtask

  initial begin
    int order [5];
    int gcyc  [5];
    int ng, cyc, w, lane;
    logic [15:0] o;

    vecs[0] = '{4'b0010, 4'b0011, 8'h11, 8'h22, 8'h33, 8'h44, 8'h22, 2'd1};
    vecs[1] = '{4'b0001, 4'b0000, 8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hA0, 2'd0};
    vecs[2] = '{4'b0001, 4'b0001, 8'h15, 8'h26, 8'h37, 8'h48, 8'h15, 2'd0};
    vecs[3] = '{4'b0001, 4'b0101, 8'h51, 8'h62, 8'h73, 8'h84, 8'h73, 2'd0};
    vecs[4] = '{4'b0001, 4'b1011, 8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h8D, 2'd0};
    vecs[5] = '{4'b0001, 4'b0100, 8'h9E, 8'hAF, 8'hB0, 8'hC1, 8'hB0, 2'd0};
    vecs[6] = '{4'b1000, 4'b1111, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 2'd3};
    vecs[7] = '{4'b0100, 4'b0010, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE1, 2'd2};

    reset = 1'b1;
    bus.req = '0;
    for (int i = 0; i < NR; i++) begin
      for (int j = 0; j < 4; j++) ops[i][j] = '0;
      sels[i] = '0;
    end
    apply;
    tick;
    tick;
    chk("reset_outs", 32'(outs()), 32'd0);
    reset = 1'b0;

    foreach (vecs[v]) begin
      scramble;
      lane = oh2i(vecs[v].req);
      ops[lane][0] = vecs[v].d00; ops[lane][1] = vecs[v].d01;
      ops[lane][2] = vecs[v].d10; ops[lane][3] = vecs[v].d11;
      sels[lane] = vecs[v].sel;
      apply;
      bus.req = vecs[v].req;
      tick;
      chk("vec_grant", {bus.grant, bus.busy, bus.done}, {vecs[v].req, 1'b1, 1'b0});
      bus.req = '0;
      scramble;
      apply;
      tick;
      chk("vec_done", {bus.grant, bus.done, bus.done_id, bus.result},
          {4'b0, 1'b1, vecs[v].exp_id, vecs[v].exp_result});
      tick;
      chk("vec_hold", {bus.busy, bus.done, bus.done_id, bus.result},
          {1'b0, 1'b0, vecs[v].exp_id, vecs[v].exp_result});
    end

    // Operand change during the grant cycle must not affect the result
    ops[1][0] = 8'h11; ops[1][1] = 8'h22; ops[1][2] = 8'h33; ops[1][3] = 8'h44;
    sels[1] = 4'b0011;
    apply;
    bus.req = 4'b0010;
    tick;
    chk("stab_grant", bus.grant, 4'b0010);
    bus.req = '0;
    ops[1][1] = 8'h99;
    apply;
    tick;
    chk("stab_result", {bus.done, bus.result}, {1'b1, 8'h22});
    tick;

    // Fairness from rr_ptr = 0
    reset = 1'b1;
    tick;
    reset = 1'b0;
    ng = 0;
    cyc = 0;
    bus.req = 4'hF;
    while (ng < 5 && cyc < 40) begin
      tick;
      cyc++;
      if (bus.grant != '0) begin
        order[ng] = oh2i(bus.grant);
        gcyc[ng] = cyc;
        ng++;
        bus.req = 4'hF & ~bus.grant;
      end else begin
        bus.req = 4'hF;
      end
    end
    if (ng < 5) chk("fair_timeout", 32'(ng), 32'd5);
    for (int k = 0; k < ng; k++) begin
      chk("fair_order", 32'(order[k]), 32'(k % 4));
      if (k > 0) chk("fair_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'd3);
    end
    bus.req = '0;
    tick;
    tick;
    tick;

    // Wrap and skip
    serve(4'b0100, w); chk("wrap_pre", 32'(w), 32'd2);
    serve(4'b1001, w); chk("wrap_first", 32'(w), 32'd3);
    serve(4'b1001, w); chk("wrap_second", 32'(w), 32'd0);
    serve(4'b0100, w); chk("skip_pre", 32'(w), 32'd2);
    serve(4'b0101, w); chk("skip_first", 32'(w), 32'd0);
    serve(4'b0101, w); chk("skip_second", 32'(w), 32'd2);

    // Reset in ISSUE aborts the operation; rr_ptr returns to 0
    serve(4'b0100, w);
    bus.req = 4'b0100;
    tick;
    chk("abort_grant", bus.grant, 4'b0100);
    reset = 1'b1;
    bus.req = '0;
    tick;
    chk("abort_outs", 32'(outs()), 32'd0);
    reset = 1'b0;
    tick;
    chk("abort_nodone", {bus.busy, bus.done, bus.result}, 10'd0);
    serve(4'b1111, w);
    chk("abort_rr", 32'(w), 32'd0);

    // Random traffic against the transaction model
    reset = 1'b1;
    for (int t = 0; t < 400; t++) begin
      if (t > 0) reset = ($urandom_range(0, 59) == 0);
      scramble;
      apply;
      bus.req = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      model_edge(t);
      tick;
      o = outs();
      chk("rand", 32'(o), 32'(e_out));
    end
    reset = 1'b0;
    bus.req = '0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
